// File: rtl/buffer_col_writer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : buffer_col_writer                                             |
// | Purpose  : Column-wise block buffer: fills NCOLS columns, then holds      |
// |            them frozen for a reader until released with rd_done.         |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module buffer_col_writer #(
    parameter int SAMPLE_W = 8,
    parameter int ROWS     = 8,
    parameter int NCOLS    = 14
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [ROWS*SAMPLE_W-1:0]   in_data,
    output logic                       in_ready,
    input  logic [3:0]                 rd_col,
    output logic [ROWS*SAMPLE_W-1:0]   rd_data,
    input  logic                       rd_done,
    output logic [3:0]                 wr_col,
    output logic                       buf_full,
    output logic                       busy
);

    localparam int         c_data_w = ROWS * SAMPLE_W;
    localparam logic [3:0] c_last   = 4'(NCOLS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FULL = 2'd2
    } state_t;

    state_t              r_state;
    logic [3:0]          r_wr_col;
    logic                r_in_ready;
    logic                r_buf_full;
    logic                r_busy;
    logic [c_data_w-1:0] r_mem [NCOLS];

    logic                w_accept;
    logic                w_last;
    logic [c_data_w-1:0] w_rd_data;

    assign w_accept = (r_state == FILL) && in_valid;
    assign w_last   = (r_wr_col == c_last);

    // Control FSM; status outputs are registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_wr_col   <= 4'd0;
            r_in_ready <= 1'b0;
            r_buf_full <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= FILL;
                        r_wr_col   <= 4'd0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                FILL: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state    <= FULL;
                            r_wr_col   <= 4'd0;
                            r_in_ready <= 1'b0;
                            r_buf_full <= 1'b1;
                        end else begin
                            r_wr_col <= r_wr_col + 4'd1;
                        end
                    end
                end
                FULL: begin
                    // Release with a simultaneous start skips IDLE entirely
                    if (rd_done) begin
                        r_buf_full <= 1'b0;
                        r_wr_col   <= 4'd0;
                        if (start) begin
                            r_state    <= FILL;
                            r_in_ready <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state    <= IDLE;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wr_col   <= 4'd0;
                    r_in_ready <= 1'b0;
                    r_buf_full <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // One register bank per column, written only when it is the target
    genvar c;
    generate
        for (c = 0; c < NCOLS; c++) begin : g_col
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_mem[c] <= '0;
                end else if (w_accept && (r_wr_col == 4'(c))) begin
                    r_mem[c] <= in_data;
                end
            end
        end
    endgenerate

    // Zero-latency read; indices past the last column read as zero
    always_comb begin
        w_rd_data = '0;
        for (int i = 0; i < NCOLS; i++) begin
            if (rd_col == 4'(i)) begin
                w_rd_data = r_mem[i];
            end
        end
    end

    assign rd_data  = w_rd_data;
    assign in_ready = r_in_ready;
    assign buf_full = r_buf_full;
    assign busy     = r_busy;
    assign wr_col   = r_wr_col;

endmodule
`default_nettype wire

// File: doc/buffer_col_writer.md
BUFFER_COL_WRITER -- requirements
Module: buffer_col_writer

Interface
REQ-001 Parameter SAMPLE_W SHALL be defined as: default 8, bits per sample.
REQ-002 Parameter ROWS SHALL be defined as: default 8, samples per column.
REQ-003 Parameter NCOLS SHALL be defined as: default 14, number of buffer columns, indices 0..13; legal range 2..16.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports SHALL be as follows.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to begin filling a new block.
- in_valid  in  1  in_data holds one column.
- in_data  in  ROWS*SAMPLE_W  one column; row 0 in the LSBs.
- in_ready  out  1  block accepts a column this cycle.
- rd_col  in  4  column index driven by the reader loop counter.
- rd_data  out  ROWS*SAMPLE_W  contents of column rd_col.
- rd_done  in  1  single-cycle pulse from the reader: buffer released.
- wr_col  out  4  index of the next column to be written.
- buf_full  out  1  all NCOLS columns written; contents stable for the reader.
- busy  out  1  FSM not in IDLE.

Function
REQ-006 The FSM SHALL have three states: IDLE, FILL and FULL.
REQ-007 In IDLE, start=1 SHALL move the FSM to FILL with wr_col=0; in_valid SHALL be ignored in IDLE.
REQ-008 in_ready SHALL be 1 only in FILL.
REQ-009 A column SHALL be accepted on an edge where in_valid=1 and in_ready=1.
REQ-010 On acceptance, in_data SHALL be stored at column wr_col, and wr_col SHALL increment by 1 on the same edge.
REQ-011 in_valid=0 in FILL SHALL hold wr_col and storage unchanged, with no timeout.
REQ-012 Acceptance at wr_col=NCOLS-1 SHALL move the FSM to FULL, wr_col SHALL wrap to 0, and buf_full SHALL be 1 from the next cycle.
REQ-013 In FULL, in_ready SHALL be 0 and storage SHALL be frozen.
REQ-014 In FULL, start without rd_done SHALL be ignored, not queued.
REQ-015 In FULL, rd_done=1 SHALL move the FSM to IDLE and clear buf_full on the same edge.
REQ-016 In FULL, rd_done=1 and start=1 on the same edge SHALL move the FSM directly to FILL with wr_col=0; no IDLE cycle SHALL occur.
REQ-017 rd_done outside FULL SHALL be ignored.
REQ-018 start in FILL SHALL be ignored; the fill in progress continues.
REQ-019 rd_data SHALL be a combinational read of column rd_col with zero latency; a column written at edge N SHALL be visible on rd_data after edge N.
REQ-020 rd_col >= NCOLS SHALL give rd_data = 0.
REQ-021 Reads SHALL be allowed in any state; reads in FILL SHALL return current contents, partially filled or stale.
REQ-022 wr_col SHALL never exceed NCOLS-1; the counter SHALL be 4 bits wide and unsigned.
REQ-023 busy SHALL be 1 in FILL and FULL, and 0 in IDLE.

Reset
REQ-024 When rst_n=0 the block SHALL, asynchronously and in any state including mid-FILL, enter IDLE and force wr_col=0, buf_full=0, in_ready=0, busy=0, and clear all storage to 0, so rd_data=0 for every rd_col.
REQ-025 After rst_n deasserts, the first state change SHALL be on a rising edge with start=1.

Verification
REQ-026 Basic fill: reset, start, then 14 consecutive columns with column k = all bytes k+1 -> wr_col steps 0..13 then 0; buf_full=1 one cycle after the 14th acceptance; rd_col=5 gives all bytes 0x06.
REQ-027 Backpressure gaps: during FILL, drop in_valid for 3 cycles after column 4 -> wr_col holds at 5 and storage is unchanged; after 14 total acceptances, buf_full=1.
REQ-028 Frozen buffer: in FULL, in_valid=1 with data 0xFF.. for 5 cycles, then start alone -> in_ready=0, rd_data unchanged, FSM stays FULL; then rd_done -> IDLE, buf_full=0, busy=0.
REQ-029 Simultaneous release and restart: in FULL, assert rd_done and start on the same edge -> next cycle FILL, in_ready=1, wr_col=0, buf_full=0.
REQ-030 Reset mid-operation: assert rst_n=0 after 7 columns, between clock edges -> outputs clear immediately; rd_data=0 for rd_col=0..15; no acceptance until a new start.
REQ-031 Out-of-range read: rd_col=14 and rd_col=15 in FULL -> rd_data=0.
